// File: rtl/mips_issue_scoreboard.sv
// mips_issue_scoreboard
// In-order issue scoreboard between ID and EX. Tracks in-flight register
// writes in a shift register of pipeline slots and stalls any instruction
// whose source register is still being produced and cannot be forwarded yet.

module mips_issue_scoreboard #(
   parameter int REG_ADDR_W  = 5,
   parameter int DEPTH       = 3,
   parameter int ALU_READY   = 0,
   parameter int LOAD_READY  = 1,
   parameter int FLUSH_DEPTH = 1
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               issue_valid,
   input  logic [REG_ADDR_W-1:0]              issue_rs,
   input  logic [REG_ADDR_W-1:0]              issue_rt,
   input  logic                               issue_uses_rs,
   input  logic                               issue_uses_rt,
   input  logic                               issue_writes,
   input  logic [REG_ADDR_W-1:0]              issue_rd,
   input  logic                               issue_is_load,
   input  logic                               flush,
   output logic                               stall,
   output logic                               issue_fire,
   output logic [(1<<REG_ADDR_W)-1:0]         pending_mask,
   output logic [$clog2(DEPTH+1)-1:0]         inflight_count
);

   localparam int NREG  = 1 << REG_ADDR_W;
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Slot i holds the instruction issued i+1 cycles ago; slot 0 is youngest.
   logic [DEPTH-1:0]                  r_slotValid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]  r_slotRd;
   logic [DEPTH-1:0]                  r_slotLoad;

   logic [DEPTH-1:0]                  w_nextValid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]  w_nextRd;
   logic [DEPTH-1:0]                  w_nextLoad;

   logic                              w_hazard;
   logic [NREG-1:0]                   w_pendingMask;
   logic [CNT_W-1:0]                  w_inflightCount;

   // A source conflicts with a slot while that slot's result is still inside
   // its non-forwardable window; $0 and unused sources never conflict.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_slotValid[i] && (i < (r_slotLoad[i] ? LOAD_READY : ALU_READY))) begin
            if (issue_uses_rs && (issue_rs != '0) && (r_slotRd[i] == issue_rs)) begin
               w_hazard = 1'b1;
            end
            if (issue_uses_rt && (issue_rt != '0) && (r_slotRd[i] == issue_rt)) begin
               w_hazard = 1'b1;
            end
         end
      end
   end

   // Flush wins over both stalling and issuing; a flushed instruction is dropped.
   assign stall      = issue_valid && w_hazard && !flush;
   assign issue_fire = issue_valid && !w_hazard && !flush;

   // Next slot contents: everything ages by one and the oldest retires.
   // On flush the youngest FLUSH_DEPTH entries are turned into bubbles as
   // they move, and no new entry enters slot 0 because issue_fire is low.
   always_comb begin
      w_nextValid = '0;
      w_nextRd    = '0;
      w_nextLoad  = '0;
      for (int i = 1; i < DEPTH; i++) begin
         w_nextRd[i]    = r_slotRd[i-1];
         w_nextLoad[i]  = r_slotLoad[i-1];
         w_nextValid[i] = r_slotValid[i-1] && !(flush && (i <= FLUSH_DEPTH));
      end
      w_nextValid[0] = issue_fire && issue_writes && (issue_rd != '0);
      w_nextRd[0]    = issue_rd;
      w_nextLoad[0]  = issue_is_load;
   end

   // Slot register; reset clears every in-flight entry and beats flush/issue.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_slotValid <= '0;
         r_slotRd    <= '0;
         r_slotLoad  <= '0;
      end else begin
         r_slotValid <= w_nextValid;
         r_slotRd    <= w_nextRd;
         r_slotLoad  <= w_nextLoad;
      end
   end

   // Decode the slot state into a per-register pending mask and a valid count.
   // Register 0 is never stored as valid, so its mask bit stays clear.
   always_comb begin
      w_pendingMask   = '0;
      w_inflightCount = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_slotValid[i]) begin
            w_pendingMask[r_slotRd[i]] = 1'b1;
         end
         w_inflightCount = w_inflightCount + CNT_W'(r_slotValid[i]);
      end
   end

   assign pending_mask   = w_pendingMask;
   assign inflight_count = w_inflightCount;

endmodule

// File: tb/tb_mips_issue_scoreboard.sv
// Testbench for mips_issue_scoreboard. Two instances share one stimulus
// stream: A uses the default forwarding latencies, B uses ALU_READY =
// LOAD_READY = 3. A bench model keeps a list of in-flight writers with their
// age; each cycle it predicts the outputs, pushes them to a queue, and the
// sampled DUT outputs are compared against the popped prediction.

module tb_mips_issue_scoreboard;

   localparam int DEPTH = 3;
   localparam int FD    = 1;
   localparam int AR_A  = 0;
   localparam int LR_A  = 1;
   localparam int AR_B  = 3;
   localparam int LR_B  = 3;

   typedef struct {
      logic [4:0] rd;
      logic       ld;
      int         age;
   } entry_t;
   typedef entry_t entryQ_t[$];

   typedef struct {
      logic        stallA;
      logic        fireA;
      logic [31:0] maskA;
      int          cntA;
      logic        stallB;
      logic        fireB;
      logic [31:0] maskB;
      int          cntB;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic        issueValid;
   logic [4:0]  issueRs;
   logic [4:0]  issueRt;
   logic        issueUsesRs;
   logic        issueUsesRt;
   logic        issueWrites;
   logic [4:0]  issueRd;
   logic        issueIsLoad;
   logic        flush;

   logic        stallA;
   logic        fireA;
   logic [31:0] maskA;
   logic [1:0]  countA;
   logic        stallB;
   logic        fireB;
   logic [31:0] maskB;
   logic [1:0]  countB;

   entryQ_t flightA;
   entryQ_t flightB;
   exp_t    expQ[$];

   int checks;
   int errors;

   mips_issue_scoreboard #(
      .REG_ADDR_W(5), .DEPTH(DEPTH), .ALU_READY(AR_A),
      .LOAD_READY(LR_A), .FLUSH_DEPTH(FD)
   ) dutA (
      .CLK(CLK), .RST(RST), .issue_valid(issueValid),
      .issue_rs(issueRs), .issue_rt(issueRt),
      .issue_uses_rs(issueUsesRs), .issue_uses_rt(issueUsesRt),
      .issue_writes(issueWrites), .issue_rd(issueRd),
      .issue_is_load(issueIsLoad), .flush(flush),
      .stall(stallA), .issue_fire(fireA),
      .pending_mask(maskA), .inflight_count(countA)
   );

   mips_issue_scoreboard #(
      .REG_ADDR_W(5), .DEPTH(DEPTH), .ALU_READY(AR_B),
      .LOAD_READY(LR_B), .FLUSH_DEPTH(FD)
   ) dutB (
      .CLK(CLK), .RST(RST), .issue_valid(issueValid),
      .issue_rs(issueRs), .issue_rt(issueRt),
      .issue_uses_rs(issueUsesRs), .issue_uses_rt(issueUsesRt),
      .issue_writes(issueWrites), .issue_rd(issueRd),
      .issue_is_load(issueIsLoad), .flush(flush),
      .stall(stallB), .issue_fire(fireB),
      .pending_mask(maskB), .inflight_count(countB)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Counts one comparison and reports it when the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // A source hits a writer whose age is still below its forwarding latency.
   function automatic logic modelHazard(input entryQ_t q, input int ar, input int lr);
      logic hit;
      int   ready;
      hit = 1'b0;
      foreach (q[k]) begin
         ready = q[k].ld ? lr : ar;
         if (q[k].age < ready) begin
            if (issueUsesRs && issueRs != 5'd0 && issueRs == q[k].rd) hit = 1'b1;
            if (issueUsesRt && issueRt != 5'd0 && issueRt == q[k].rd) hit = 1'b1;
         end
      end
      return hit;
   endfunction

   function automatic logic [31:0] modelMask(input entryQ_t q);
      logic [31:0] m;
      m = 32'd0;
      foreach (q[k]) m[q[k].rd] = 1'b1;
      return m;
   endfunction

   // Ages the writer list across one clock edge.
   function automatic entryQ_t modelEdge(input entryQ_t q, input logic rst, input logic fl,
                                         input logic ins, input logic [4:0] rd, input logic ld);
      entryQ_t n;
      entry_t  e;
      n = {};
      if (rst) return n;
      foreach (q[k]) begin
         if (fl && q[k].age < FD) continue;
         if (q[k].age + 1 < DEPTH) begin
            e = q[k];
            e.age = e.age + 1;
            n.push_back(e);
         end
      end
      if (ins) begin
         e.rd  = rd;
         e.ld  = ld;
         e.age = 0;
         n.push_back(e);
      end
      return n;
   endfunction

   // Drives one cycle of inputs, predicts and checks the outputs, then
   // advances the model over the clock edge.
   task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic wr,
                                input logic [4:0] rd, input logic ld, input logic fl,
                                input logic rst);
      exp_t e;
      exp_t got;
      logic hazA;
      logic hazB;
      issueValid  = v;
      issueRs     = rs;
      issueRt     = rt;
      issueUsesRs = urs;
      issueUsesRt = urt;
      issueWrites = wr;
      issueRd     = rd;
      issueIsLoad = ld;
      flush       = fl;
      RST         = rst;
      hazA     = modelHazard(flightA, AR_A, LR_A);
      hazB     = modelHazard(flightB, AR_B, LR_B);
      e.stallA = v && hazA && !fl;
      e.fireA  = v && !hazA && !fl;
      e.maskA  = modelMask(flightA);
      e.cntA   = flightA.size();
      e.stallB = v && hazB && !fl;
      e.fireB  = v && !hazB && !fl;
      e.maskB  = modelMask(flightB);
      e.cntB   = flightB.size();
      expQ.push_back(e);
      #4;
      got = expQ.pop_front();
      checkOutput("stallA", {31'd0, stallA}, {31'd0, got.stallA});
      checkOutput("fireA",  {31'd0, fireA},  {31'd0, got.fireA});
      checkOutput("maskA",  maskA,           got.maskA);
      checkOutput("countA", {30'd0, countA}, got.cntA);
      checkOutput("stallB", {31'd0, stallB}, {31'd0, got.stallB});
      checkOutput("fireB",  {31'd0, fireB},  {31'd0, got.fireB});
      checkOutput("maskB",  maskB,           got.maskB);
      checkOutput("countB", {30'd0, countB}, got.cntB);
      @(posedge CLK);
      flightA = modelEdge(flightA, rst, fl, got.fireA && wr && rd != 5'd0, rd, ld);
      flightB = modelEdge(flightB, rst, fl, got.fireB && wr && rd != 5'd0, rd, ld);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      RST         = 1'b1;
      issueValid  = 1'b0;
      issueRs     = '0;
      issueRt     = '0;
      issueUsesRs = 1'b0;
      issueUsesRt = 1'b0;
      issueWrites = 1'b0;
      issueRd     = '0;
      issueIsLoad = 1'b0;
      flush       = 1'b0;
      flightA     = {};
      flightB     = {};
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Reset state.
      idle(1);

      // addi $2 then add $3,$2,$2 (ALU forwarding).
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd2, 0, 0, 0);
      for (int k = 0; k < 4; k++) applyStimulus(1, 5'd2, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0);
      idle(3);

      // lw $4 then add $5,$4,$1 (load-use).
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd4, 1, 0, 0);
      for (int k = 0; k < 4; k++) applyStimulus(1, 5'd4, 5'd1, 1, 1, 1, 5'd5, 0, 0, 0);
      idle(3);

      // ALU writer of $7 then a held dependent.
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
      for (int k = 0; k < 5; k++) applyStimulus(1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0);
      idle(3);

      // Writer of $0 then reader of $0.
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd0, 0, 0, 0);
      applyStimulus(1, 5'd0, 5'd0, 1, 1, 1, 5'd6, 0, 0, 0);
      idle(3);

      // lw $8, flush on the next instruction, then reader of $8.
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd8, 1, 0, 0);
      applyStimulus(1, 5'd1, 5'd1, 1, 1, 1, 5'd12, 0, 1, 0);
      for (int k = 0; k < 3; k++) applyStimulus(1, 5'd8, 5'd8, 1, 1, 0, 5'd0, 0, 0, 0);
      idle(3);

      // Fill with writers of $9..$11, reset with an issue present, read $9.
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd10, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd11, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd13, 1, 1, 1);
      applyStimulus(1, 5'd9, 5'd13, 1, 1, 0, 5'd0, 0, 0, 0);
      idle(2);

      // Random traffic over a small register range to provoke hazards.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 49) == 0));
      end

      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL leftoverExpected: got %0d expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
